alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one 64-bit ALU (existing module alu, cntrl encoding PASS_B=000, ADD=010, SUBTRACT=011, AND=100, OR=101, XOR=110) between two requesters.
Arbitration is round-robin, with a valid/ready request handshake and a registered response channel.
The block also owns the architectural flag register {N,Z,V,C}, updated only by requests with setflags=1.
It sits between the issue logic (requester 0) and an auxiliary address/compare path (requester 1).

Parameters:
DATA_W, 64, operand/result width (must match alu; only 64 supported)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_A, req0_B  in  DATA_W  requester 0 operands
req0_cntrl  in  3  requester 0 ALU op
req0_setflags  in  1  requester 0 op updates flag register
req1_valid, req1_ready, req1_A, req1_B, req1_cntrl, req1_setflags  same as req0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the response
rsp_result  out  DATA_W  ALU result
rsp_flags  out  4  {negative, zero, overflow, carry_out} of this op
rsp_err  out  1  illegal cntrl (001 or 111)
flags_q  out  4  architectural flags {N,Z,V,C}

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, flags_q=0, last_grant=1 (requester 0 wins first).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, only for the granted requester.
  - Grant rule: the sole valid requester wins; if both are valid, the requester != last_grant wins.
  - On the handshake: latch A, B, cntrl, setflags and id into operand regs, update last_grant, go to EXEC.
  - With no valid requester, stay in IDLE; both readys are 0.
- EXEC:
  - The ALU is driven only from the operand regs; requester inputs never reach it directly.
  - At the end of the cycle, capture result and flags into the rsp_* regs and go to RESP.
  - Illegal cntrl: rsp_result=0, rsp_flags=0, rsp_err=1, flags_q unchanged.
- RESP:
  - rsp_valid=1; all rsp_* outputs are held stable until rsp_ready=1.
  - On the handshake, go to IDLE. No new request is accepted in the same cycle.
- Latency and throughput:
  - Request accepted at cycle t → rsp_valid first high at t+2.
  - Minimum spacing is 3 cycles per operation.
- Flag update, applied in the EXEC cycle with setflags=1 and a legal op:
  - ADD/SUBTRACT: N, Z, V, C all written.
  - PASS_B/AND/OR/XOR: N and Z written; V and C hold.
  - setflags=0: no change.
- Flag source: Z is 1 iff result == 0; N = result[63]. C and V are taken from the alu outputs; subtract sets C=1 when there is no borrow.
- Input stability: requester inputs are not required to be stable after the handshake.
- Reset mid-operation: abandon any in-flight op; no response is produced and flags_q is cleared.
- Simultaneous valid from both requesters: strict alternation while both stay valid, i.e. no requester is starved for more than one op.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] alu_op_t, holding the six cntrl codes;
  - typedef struct flags_t {n,z,v,c};
  - localparam DATA_W=64;
  - function is_legal_op.
- FSM state typedef stays local to the module.
- One sub-module: the existing alu, instantiated once.
- The round-robin grant is inline (2 requesters); no separate arbiter module.

Test Plan:
- req0 ADD A=254, B=1, setflags=1 → rsp_valid at t+2, rsp_id=0, rsp_result=255, rsp_flags=0000, flags_q=0000.
- Both valid from reset, req0 SUB 0−0 and req1 ADD 1+1, held valid for 4 ops → grant order 0,1,0,1; first rsp_result=0 with flags Z=1, C=1.
- ADD A=B=64'h7FFF_FFFF_FFFF_FFFF with setflags=1, then AND 3&5 with setflags=1 → first: V=1, N=1. After AND: rsp_result=1, N=0, Z=0, V=1 and C held.
- Backpressure: rsp_ready=0 for 5 cycles with req1_valid=1 → rsp_* stable, req1_ready=0 throughout; accepted the cycle after the response handshake.
- req0 cntrl=3'b111, setflags=1 → rsp_err=1, rsp_result=0, flags_q unchanged.
- reset asserted during EXEC → next cycle rsp_valid=0, flags_q=0, state IDLE; then with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter slice.
// ALU opcodes, flag bundle and opcode legality.
package alu_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        OP_PASS_B = 3'b000,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    function automatic logic is_legal_op(
        input logic [2:0] op
    );
        return !(op == 3'b001 || op == 3'b111);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two request channels, one response channel
// and the architectural flags of the shared ALU.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_A;
    logic [DATA_W-1:0] req0_B;
    logic [2:0]        req0_cntrl;
    logic              req0_setflags;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_A;
    logic [DATA_W-1:0] req1_B;
    logic [2:0]        req1_cntrl;
    logic              req1_setflags;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;
    logic [3:0]        flags_q;

    modport master (
        output req0_valid, req0_A, req0_B,
        output req0_cntrl, req0_setflags,
        output req1_valid, req1_A, req1_B,
        output req1_cntrl, req1_setflags,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        input  rsp_flags, rsp_err, flags_q
    );

    modport slave (
        input  req0_valid, req0_A, req0_B,
        input  req0_cntrl, req0_setflags,
        input  req1_valid, req1_A, req1_B,
        input  req1_cntrl, req1_setflags,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        output rsp_flags, rsp_err, flags_q
    );

endinterface

// File: rtl/alu.sv
// 64-bit combinational ALU; subtract reports
// carry_out=1 when no borrow occurs.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        cntrl,
    output logic [DATA_W-1:0] result,
    output logic              negative,
    output logic              zero,
    output logic              overflow,
    output logic              carry_out
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum       = '0;
        result    = '0;
        overflow  = 1'b0;
        carry_out = 1'b0;
        unique case (cntrl)
            OP_PASS_B: result = B;
            OP_ADD: begin
                sum       = {1'b0, A} + {1'b0, B};
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
                overflow  = (A[DATA_W-1] == B[DATA_W-1])
                         && (result[DATA_W-1] != A[DATA_W-1]);
            end
            OP_SUB: begin
                sum       = {1'b0, A} + {1'b0, ~B}
                          + {{DATA_W{1'b0}}, 1'b1};
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
                overflow  = (A[DATA_W-1] != B[DATA_W-1])
                         && (result[DATA_W-1] != A[DATA_W-1]);
            end
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            default: result = '0;
        endcase
    end

    assign negative = result[DATA_W-1];
    assign zero     = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters,
// with a registered response and the architectural flags.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, state_n;

    logic              last_grant;
    logic              grant_id;
    logic              any_valid;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [2:0]        op_cntrl;
    logic              op_set;
    logic              op_id;

    logic [DATA_W-1:0] alu_res;
    logic              alu_n, alu_z, alu_v, alu_c;
    flags_t            alu_fl;
    flags_t            flags_r;
    logic              op_legal;
    logic              op_arith;

    alu u_alu (
        .A         (op_a),
        .B         (op_b),
        .cntrl     (op_cntrl),
        .result    (alu_res),
        .negative  (alu_n),
        .zero      (alu_z),
        .overflow  (alu_v),
        .carry_out (alu_c)
    );

    assign alu_fl   = {alu_n, alu_z, alu_v, alu_c};
    assign op_legal = is_legal_op(op_cntrl);
    assign op_arith = (op_cntrl == OP_ADD)
                   || (op_cntrl == OP_SUB);

    // On contention the requester that did not win last time goes.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant_id  = (bus.req0_valid && bus.req1_valid)
                     ? ~last_grant : bus.req1_valid;

    always_comb begin
        state_n        = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req0_ready = any_valid && !grant_id;
                bus.req1_ready = any_valid &&  grant_id;
                if (any_valid) state_n = EXEC;
            end
            EXEC:    state_n = RESP;
            RESP:    if (bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant     <= 1'b1;
            op_a           <= '0;
            op_b           <= '0;
            op_cntrl       <= '0;
            op_set         <= 1'b0;
            op_id          <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
            bus.rsp_err    <= 1'b0;
            flags_r        <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                last_grant <= grant_id;
                op_id      <= grant_id;
                op_a       <= grant_id ? bus.req1_A
                                       : bus.req0_A;
                op_b       <= grant_id ? bus.req1_B
                                       : bus.req0_B;
                op_cntrl   <= grant_id ? bus.req1_cntrl
                                       : bus.req0_cntrl;
                op_set     <= grant_id ? bus.req1_setflags
                                       : bus.req0_setflags;
            end
            if (state == EXEC) begin
                bus.rsp_id     <= op_id;
                bus.rsp_err    <= !op_legal;
                bus.rsp_result <= op_legal ? alu_res : '0;
                bus.rsp_flags  <= op_legal ? alu_fl  : '0;
                // Logic ops leave V and C untouched.
                if (op_set && op_legal) begin
                    flags_r.n <= alu_fl.n;
                    flags_r.z <= alu_fl.z;
                    if (op_arith) begin
                        flags_r.v <= alu_fl.v;
                        flags_r.c <= alu_fl.c;
                    end
                end
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.flags_q   = flags_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a per-cycle
// reference model of grants, responses and flags.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  fl;
        logic        err;
        logic        id;
        logic [3:0]  nf;
    } ent_t;

    function automatic ent_t model_op(
        input logic        id,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [2:0]  op,
        input logic        sf,
        input logic [3:0]  arch
    );
        ent_t e;
        logic [63:0] r;
        logic n, z, v, c;
        bit full, legal;
        legal = 1; full = 0;
        v = 0; c = 0; r = '0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                r = a + b;
                c = (r < a);
                v = ($signed(a) >= 0 && $signed(b) >= 0
                     && $signed(r) < 0)
                 || ($signed(a) < 0 && $signed(b) < 0
                     && $signed(r) >= 0);
                full = 1;
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                v = ($signed(a) >= 0 && $signed(b) < 0
                     && $signed(r) < 0)
                 || ($signed(a) < 0 && $signed(b) >= 0
                     && $signed(r) >= 0);
                full = 1;
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: legal = 0;
        endcase
        n = r[63];
        z = (r == 0);
        e.id = id;
        if (!legal) begin
            e.res = '0; e.fl = '0;
            e.err = 1;  e.nf = arch;
        end else begin
            e.res = r;
            e.fl  = {n, z, v, c};
            e.err = 0;
            if (!sf)       e.nf = arch;
            else if (full) e.nf = {n, z, v, c};
            else           e.nf = {n, z, arch[1:0]};
        end
        return e;
    endfunction

    bit         mv = 0;
    bit         pend = 0;
    bit         lg = 1;
    int         age = 0;
    ent_t       ent;
    logic [3:0] arch = '0;

    always @(negedge clk) begin
        bit er0, er1, ev;
        er0 = !pend && bus.req0_valid
           && (!bus.req1_valid || lg);
        er1 = !pend && bus.req1_valid
           && (!bus.req0_valid || !lg);
        ev  = pend && age >= 2;
        if (mv) begin
            check("m_req0_ready", bus.req0_ready, er0);
            check("m_req1_ready", bus.req1_ready, er1);
            check("m_rsp_valid", bus.rsp_valid, ev);
            check("m_flags_q", bus.flags_q,
                  ev ? ent.nf : arch);
            if (ev) begin
                check("m_rsp_id", bus.rsp_id, ent.id);
                check("m_rsp_result", bus.rsp_result,
                      ent.res);
                check("m_rsp_flags", bus.rsp_flags, ent.fl);
                check("m_rsp_err", bus.rsp_err, ent.err);
            end
        end
        if (reset) begin
            mv = 1; pend = 0; lg = 1; arch = '0;
        end else if (pend) begin
            if (ev && bus.rsp_ready) begin
                arch = ent.nf;
                pend = 0;
            end else begin
                age++;
            end
        end else if (er0 || er1) begin
            ent = er1
                ? model_op(1, bus.req1_A, bus.req1_B,
                           bus.req1_cntrl,
                           bus.req1_setflags, arch)
                : model_op(0, bus.req0_A, bus.req0_B,
                           bus.req0_cntrl,
                           bus.req0_setflags, arch);
            pend = 1; age = 1; lg = er1;
        end
    end

    task automatic drive(input bit id,
                         input logic [63:0] a,
                         input logic [63:0] b,
                         input logic [2:0] op,
                         input bit sf);
        if (id) begin
            bus.req1_A = a; bus.req1_B = b;
            bus.req1_cntrl = op;
            bus.req1_setflags = sf;
            bus.req1_valid = 1;
        end else begin
            bus.req0_A = a; bus.req0_B = b;
            bus.req0_cntrl = op;
            bus.req0_setflags = sf;
            bus.req0_valid = 1;
        end
    endtask

    task automatic wait_any(output bit g);
        int n = 0;
        @(negedge clk);
        while (!(bus.req0_ready || bus.req1_ready)) begin
            n++;
            if (n > 50) begin
                timeout("wait_ready");
                break;
            end
            @(negedge clk);
        end
        g = bus.req1_ready;
    endtask

    task automatic issue(input bit id,
                         input logic [63:0] a,
                         input logic [63:0] b,
                         input logic [2:0] op,
                         input bit sf);
        bit g;
        drive(id, a, b, op, sf);
        wait_any(g);
        check("issue_grant", g, id);
        @(posedge clk); #1;
        if (id) bus.req1_valid = 0;
        else    bus.req0_valid = 0;
    endtask

    int          lat;
    logic        r_id;
    logic [63:0] r_res;
    logic [3:0]  r_fl;
    logic        r_err;

    task automatic get_rsp();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 50);
        if (!bus.rsp_valid) timeout("rsp_valid");
        r_id  = bus.rsp_id;
        r_res = bus.rsp_result;
        r_fl  = bus.rsp_flags;
        r_err = bus.rsp_err;
        if (bus.rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit g;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_A = '0; bus.req0_B = '0;
        bus.req1_A = '0; bus.req1_B = '0;
        bus.req0_cntrl = '0; bus.req1_cntrl = '0;
        bus.req0_setflags = 0; bus.req1_setflags = 0;
        bus.rsp_ready = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_flags", bus.rsp_flags, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_flags_q", bus.flags_q, 0);
        @(posedge clk); #1 reset = 0;

        issue(0, 64'd254, 64'd1, 3'b010, 1);
        get_rsp();
        check("add_latency", lat, 2);
        check("add_id", r_id, 0);
        check("add_result", r_res, 64'd255);
        check("add_flags", r_fl, 4'b0000);
        check("add_flags_q", bus.flags_q, 4'b0000);

        reset = 1;
        @(posedge clk); #1 reset = 0;
        drive(0, 64'd0, 64'd0, 3'b011, 1);
        drive(1, 64'd1, 64'd1, 3'b010, 1);
        for (int k = 0; k < 4; k++) begin
            wait_any(g);
            check("rr_grant", g, k % 2);
            @(posedge clk); #1;
            if (k == 3) begin
                bus.req0_valid = 0;
                bus.req1_valid = 0;
            end
            get_rsp();
            check("rr_id", r_id, g);
            check("rr_result", r_res, g ? 64'd2 : 64'd0);
            if (k == 0) check("rr_sub_flags", r_fl, 4'b0101);
        end

        issue(0, 64'h7FFF_FFFF_FFFF_FFFF,
              64'h7FFF_FFFF_FFFF_FFFF, 3'b010, 1);
        get_rsp();
        check("ovf_result", r_res, 64'hFFFF_FFFF_FFFF_FFFE);
        check("ovf_flags", r_fl, 4'b1010);
        issue(0, 64'd3, 64'd5, 3'b100, 1);
        get_rsp();
        check("and_result", r_res, 64'd1);
        check("and_flags_q", bus.flags_q, 4'b0010);

        issue(0, 64'd10, 64'd3, 3'b011, 0);
        bus.rsp_ready = 0;
        drive(1, 64'd5, 64'd8, 3'b101, 0);
        get_rsp();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_result", bus.rsp_result, 64'd7);
            check("bp_id", bus.rsp_id, 0);
            check("bp_req1_ready", bus.req1_ready, 0);
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        check("bp_after_valid", bus.rsp_valid, 0);
        check("bp_after_ready", bus.req1_ready, 1);
        @(posedge clk); #1 bus.req1_valid = 0;
        get_rsp();
        check("bp_or_id", r_id, 1);
        check("bp_or_result", r_res, 64'd13);

        issue(0, 64'd9, 64'd9, 3'b111, 1);
        get_rsp();
        check("ill_err", r_err, 1);
        check("ill_result", r_res, 64'd0);
        check("ill_flags", r_fl, 4'b0000);
        check("ill_flags_q", bus.flags_q, 4'b0010);

        issue(0, 64'd0, 64'd0, 3'b011, 1);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        drive(0, 64'd6, 64'd3, 3'b110, 1);
        drive(1, 64'd1, 64'd2, 3'b010, 0);
        @(negedge clk);
        check("mid_rst_valid", bus.rsp_valid, 0);
        check("mid_rst_flags_q", bus.flags_q, 4'b0000);
        check("mid_rst_ready0", bus.req0_ready, 1);
        check("mid_rst_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        get_rsp();
        check("mid_rst_id", r_id, 0);
        check("mid_rst_result", r_res, 64'd5);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
